// File: rtl/dct_transpose_ctrl.sv
// rtl/dct_transpose_ctrl.sv - ping-pong transpose buffer controller between row and column DCT passes
module dct_transpose_ctrl #(
    parameter int  DATA_WIDTH = 10,
    parameter int  N          = 8,
    localparam int ADDR_W     = $clog2(2 * N * N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_wr_en,
    output logic [ADDR_W-1:0]     ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_W-1:0]     ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  block_done
);

    localparam int NN   = N * N;
    localparam int CW   = $clog2(NN);
    localparam int LOGN = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic          wr_bank, rd_bank;
    logic [1:0]    bank_full;
    logic [1:0]    set_mask, clr_mask;
    logic          wr_fire, wr_last, rd_last;

    // Writer owns only a non-full bank; held off while reset is asserted.
    assign in_ready    = rst_n & ~bank_full[wr_bank];
    assign wr_fire     = in_valid & in_ready;
    assign wr_last     = wr_fire & (wr_cnt == CW'(NN - 1));
    assign rd_last     = (state == READ) & (rd_cnt == CW'(NN - 1));

    assign ram_wr_en   = wr_fire;
    assign ram_wr_addr = {wr_bank, wr_cnt};
    assign ram_wr_data = in_data;

    // Column-major walk: low bits of the count select the row, high bits the column.
    assign ram_rd_en   = (state == READ);
    assign ram_rd_addr = {rd_bank, rd_cnt[LOGN-1:0], rd_cnt[CW-1:LOGN]};

    assign out_data    = out_valid ? ram_rd_data : '0;

    // Write pointer: advances only on accepted samples, flips bank at block end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (wr_fire) begin
            if (wr_last) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_cnt <= wr_cnt + CW'(1);
            end
        end
    end

    // Per-bank set/clear requests; writer and reader never target the same bank together.
    always_comb begin
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (wr_last) set_mask[wr_bank] = 1'b1;
        if (rd_last) clr_mask[rd_bank] = 1'b1;
    end

    // Bank ownership flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_full <= 2'b00;
        else        bank_full <= (bank_full | set_mask) & ~clr_mask;
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; at a block end the other bank counts as ready if its fill completes
    // this same cycle, so back-to-back blocks stream with no output gap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bank_full[rd_bank]) state_nxt = READ;
            READ: if (rd_last) state_nxt = (bank_full[~rd_bank] | set_mask[~rd_bank]) ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Read pointer: runs every READ cycle, flips bank after the last read of a block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (rd_last) begin
            rd_cnt  <= '0;
            rd_bank <= ~rd_bank;
        end else if (state == READ) begin
            rd_cnt <= rd_cnt + CW'(1);
        end
    end

    // Output qualifiers track the one-cycle RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            block_done <= 1'b0;
        end else begin
            out_valid  <= ram_rd_en;
            block_done <= rd_last;
        end
    end

endmodule

// File: tb/tb_dct_transpose_ctrl.sv
// tb/tb_dct_transpose_ctrl.sv - randomized self-checking bench for dct_transpose_ctrl
module tb_dct_transpose_ctrl;

    localparam int DW     = 10;
    localparam int N      = 8;
    localparam int NN     = N * N;
    localparam int ADDR_W = $clog2(2 * N * N);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DW-1:0]     ram_wr_data;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DW-1:0]     ram_rd_data;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              block_done;

    dct_transpose_ctrl #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .out_data(out_data), .out_valid(out_valid), .block_done(block_done)
    );

    always #5 clk = ~clk;

    // external 2-bank RAM: sync write, 1-cycle sync read
    logic [DW-1:0] mem [0:2*NN-1];
    logic [DW-1:0] rd_q = '0;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) rd_q <= mem[ram_rd_addr];
    end
    assign ram_rd_data = rd_q;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // reference model: accepted samples in order, block counters, event timestamps
    logic [DW-1:0] samples[$];
    int acc, wr_blocks, rel_blocks, rd_k, out_cnt, stalls;
    int blk_end[$];
    int ov_start[$];
    int done_at[$];

    task automatic model_clear();
        samples.delete(); blk_end.delete(); ov_start.delete(); done_at.delete();
        acc = 0; wr_blocks = 0; rel_blocks = 0; rd_k = 0; out_cnt = 0; stalls = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, ((wr_blocks - rel_blocks) < 2) ? 1 : 0);
            if (in_valid && !in_ready) stalls++;
            if (ram_rd_en) begin
                check("rd_has_block", (wr_blocks > rel_blocks) ? 1 : 0, 1);
                check("rd_addr", ram_rd_addr, (rel_blocks % 2) * NN + (rd_k % N) * N + rd_k / N);
                rd_k++;
                if (rd_k == NN) begin rd_k = 0; rel_blocks++; end
            end
            if (out_valid) begin
                if (out_cnt < wr_blocks * NN) begin
                    int b, idx;
                    b   = out_cnt / NN;
                    idx = out_cnt % NN;
                    check("out_data", out_data, samples[b * NN + (idx % N) * N + idx / N]);
                    check("block_done", block_done, (idx == NN - 1) ? 1 : 0);
                    if (idx == 0) ov_start.push_back(cyc);
                    if (idx == NN - 1) done_at.push_back(cyc);
                end else begin
                    check("out_unexpected", 1, 0);
                end
                out_cnt++;
            end else if (block_done) begin
                check("done_no_valid", 1, 0);
            end
            if (ram_wr_en) begin
                check("wr_addr", ram_wr_addr, ((acc / NN) % 2) * NN + acc % NN);
                check("wr_data", ram_wr_data, in_data);
                samples.push_back(in_data);
                acc++;
                if (acc % NN == 0) begin wr_blocks++; blk_end.push_back(cyc); end
            end
        end
    end

    // mode 0: continuous, data=index; mode 1: valid 1,0,0,1 pattern, data=index; mode 2: random
    task automatic push(input int nsamp, input int mode);
        int sent = 0;
        int c = 0;
        while (sent < nsamp && c < 20 * nsamp + 200) begin
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 4 == 0 || c % 4 == 3)
                                                        : ($urandom_range(0, 2) != 0);
            in_data  = (mode == 2) ? DW'($urandom) : DW'(sent % NN);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0;
        check("push_timeout", sent, nsamp);
    endtask

    task automatic drain();
        int c = 0;
        while ((out_cnt != wr_blocks * NN || ram_rd_en || out_valid) && c < 1000) begin
            @(posedge clk); #1; c++;
        end
        check("drain", out_cnt, wr_blocks * NN);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_wr_en"}, ram_wr_en, 0);
        check({tag, "_rd_en"}, ram_rd_en, 0);
        check({tag, "_wr_addr"}, ram_wr_addr, 0);
        check({tag, "_rd_addr"}, ram_rd_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_block_done"}, block_done, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    initial begin
        int b;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", in_ready, 1);

        // single block, latency and transpose order
        push(NN, 0);
        drain();
        check("first_out_latency", ov_start[0] - blk_end[0], 3);
        check("done_latency", done_at[0] - blk_end[0], NN + 2);

        // gapped input, same data
        push(NN, 1);
        drain();

        // three blocks back to back: one stall, continuous output
        b = wr_blocks;
        stalls = 0;
        push(3 * NN, 0);
        check("b2b_stalls", stalls, 1);
        drain();
        check("b2b_out_span", done_at[b + 2] - ov_start[b] + 1, 3 * NN);

        // randomized traffic filling both banks
        push(3 * NN, 0);
        push(2 * NN, 2);
        drain();
        check("total_out", out_cnt, acc);

        // reset mid-operation: stored and partial blocks are discarded
        push(NN + 30, 0);
        rst_n = 1'b0;
        model_clear();
        #1;
        check_quiet("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("ready_after_midreset", in_ready, 1);
        check("addr_after_midreset", ram_wr_addr, 0);
        repeat (5) @(posedge clk);
        #1;
        check("no_out_after_reset", out_cnt, 0);
        push(NN, 0);
        drain();
        check("post_reset_latency", ov_start[0] - blk_end[0], 3);
        check("post_reset_blocks", out_cnt, NN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
